// File: rtl/seq_divider_pkg.sv
// Shared utility types for the divider slice: shift selector and divider FSM states.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    SHIFT_LEFT,
    SHIFT_RIGHT,
    ROTATE_LEFT,
    ROTATE_RIGHT
  } SHIFT_TYPE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } DIV_STATE;

endpackage

// File: rtl/seq_divider_fast_adder.sv
// Grouped lookahead adder: bits ripple inside a group, group carries use generate/propagate.
module fast_adder #(
  parameter int unsigned word_width   = 8,
  parameter int unsigned cascade_size = 4
) (
  input  logic [word_width-1:0] A,
  input  logic [word_width-1:0] B,
  input  logic                  C_IN,
  output logic [word_width-1:0] SUM,
  output logic                  C_OUT
);
  localparam int unsigned NGROUPS = (word_width + cascade_size - 1) / cascade_size;

  logic [word_width-1:0] g;
  logic [word_width-1:0] p;

  assign g = A & B;
  assign p = A ^ B;

  always_comb begin
    logic carry;
    logic cbit;
    logic gg;
    logic pg;
    int unsigned idx;
    SUM   = '0;
    carry = C_IN;
    for (int unsigned grp = 0; grp < NGROUPS; grp++) begin
      gg   = 1'b0;
      pg   = 1'b1;
      cbit = carry;
      for (int unsigned k = 0; k < cascade_size; k++) begin
        idx = grp * cascade_size + k;
        if (idx < word_width) begin
          SUM[idx] = p[idx] ^ cbit;
          cbit     = g[idx] | (p[idx] & cbit);
          gg       = g[idx] | (p[idx] & gg);
          pg       = pg & p[idx];
        end
      end
      // Group carry-out comes from the lookahead terms, not the in-group ripple.
      carry = gg | (pg & carry);
    end
    C_OUT = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, signed or unsigned operands.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned word_width   = 8,
  parameter int unsigned cascade_size = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [word_width-1:0] dividend,
  input  logic [word_width-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [word_width-1:0] quotient,
  output logic [word_width-1:0] remainder,
  output logic                  div_by_zero
);
  localparam int unsigned CW = $clog2(word_width);
  localparam logic [CW-1:0] LAST = CW'(word_width - 1);
  localparam logic [word_width-1:0] ONE = {{(word_width-1){1'b0}}, 1'b1};

  DIV_STATE state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [word_width-1:0] rem_q, rem_d;
  logic [word_width-1:0] dvd_q, dvd_d;
  logic [word_width-1:0] dvsr_q, dvsr_d;
  logic                  signed_q, signed_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  dvs_neg_q, dvs_neg_d;
  logic                  zero_q, zero_d;
  logic [word_width-1:0] quotient_q, quotient_d;
  logic [word_width-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  done_q, done_d;

  logic [word_width-1:0] shifted;
  logic [word_width-1:0] dvsr_n;
  logic [word_width-1:0] diff;
  logic                  c_out;
  logic                  trial_ok;

  assign shifted  = {rem_q[word_width-2:0], dvd_q[word_width-1]};
  assign dvsr_n   = ~dvsr_q;
  // The bit shifted out of the remainder means the trial value already exceeds the divisor.
  assign trial_ok = c_out | rem_q[word_width-1];

  fast_adder #(
    .word_width  (word_width),
    .cascade_size(cascade_size)
  ) u_sub (
    .A    (shifted),
    .B    (dvsr_n),
    .C_IN (1'b1),
    .SUM  (diff),
    .C_OUT(c_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvsr_d      = dvsr_q;
    signed_d    = signed_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          signed_d  = signed_op;
          dvd_neg_d = signed_op & dividend[word_width-1];
          dvs_neg_d = signed_op & divisor[word_width-1];
          cnt_d     = '0;
          rem_d     = '0;
          if (divisor == '0) begin
            zero_d  = 1'b1;
            dvd_d   = dividend;
            state_d = FIX;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = (signed_op & dividend[word_width-1]) ? (~dividend + ONE) : dividend;
            dvsr_d  = (signed_op & divisor[word_width-1])  ? (~divisor + ONE)  : divisor;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = trial_ok ? diff : shifted;
        dvd_d = {dvd_q[word_width-2:0], trial_ok};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? (~dvd_q + ONE) : dvd_q;
          remainder_d = (signed_q & dvd_neg_q) ? (~rem_q + ONE) : rem_q;
          dbz_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvsr_q      <= '0;
      signed_q    <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvsr_q      <= dvsr_d;
      signed_q    <= signed_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
